// File: rtl/apb_demux_pkg.sv
// Shared types and sizing helpers for the APB demux and its address decoder.
// Per-instance widths come from the helper functions; sel_idx_t covers the default port count.
package apb_demux_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDecErr,
    StAbort
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

  localparam int unsigned DefaultNoMst = 4;

  typedef logic [idx_width(DefaultNoMst)-1:0] sel_idx_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational base/mask rule matcher; the lowest-indexed matching rule wins.
module apb_addr_decode
  import apb_demux_pkg::*;
#(
  parameter int unsigned NoMst     = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdxWidth  = idx_width(NoMst)
) (
  input  logic [AddrWidth-1:0]       addr,
  input  logic [NoMst*AddrWidth-1:0] base,
  input  logic [NoMst*AddrWidth-1:0] mask,
  output logic                       match_valid,
  output logic [IdxWidth-1:0]        idx
);

  always_comb begin
    match_valid = 1'b0;
    idx         = '0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = int'(NoMst) - 1; i >= 0; i--) begin
      if ((addr & mask[i*AddrWidth +: AddrWidth]) ==
          (base[i*AddrWidth +: AddrWidth] & mask[i*AddrWidth +: AddrWidth])) begin
        match_valid = 1'b1;
        idx         = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/apb_demux_timeout.sv
// One-to-NoMst APB demux with decode-error responses and a per-transfer watchdog that
// aborts a hung completer with PSLVERR.
module apb_demux_timeout
  import apb_demux_pkg::*;
#(
  parameter int unsigned NoMst         = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NoMst*AddrWidth-1:0] addr_base_i,
  input  logic [NoMst*AddrWidth-1:0] addr_mask_i,
  input  logic [AddrWidth-1:0]       slv_paddr_i,
  input  logic [2:0]                 slv_pprot_i,
  input  logic                       slv_psel_i,
  input  logic                       slv_penable_i,
  input  logic                       slv_pwrite_i,
  input  logic [DataWidth-1:0]       slv_pwdata_i,
  input  logic [DataWidth/8-1:0]     slv_pstrb_i,
  output logic                       slv_pready_o,
  output logic [DataWidth-1:0]       slv_prdata_o,
  output logic                       slv_pslverr_o,
  output logic [AddrWidth-1:0]       mst_paddr_o,
  output logic [2:0]                 mst_pprot_o,
  output logic                       mst_penable_o,
  output logic                       mst_pwrite_o,
  output logic [DataWidth-1:0]       mst_pwdata_o,
  output logic [DataWidth/8-1:0]     mst_pstrb_o,
  output logic [NoMst-1:0]           mst_psel_o,
  input  logic [NoMst-1:0]           mst_pready_i,
  input  logic [NoMst-1:0]           mst_pslverr_i,
  input  logic [NoMst*DataWidth-1:0] mst_prdata_i,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = idx_width(NoMst);
  localparam int unsigned CntW = cnt_width(TimeoutCycles);

  state_e          state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            match_valid;
  logic [IdxW-1:0] match_idx;

  logic [NoMst-1:0]     match_onehot, sel_onehot;
  logic                 sel_pready, sel_pslverr;
  logic [DataWidth-1:0] sel_prdata;

  logic [NoMst-1:0]     psel;
  logic                 pready, pslverr, timeout;
  logic [DataWidth-1:0] prdata;

  assign mst_paddr_o   = slv_paddr_i;
  assign mst_pprot_o   = slv_pprot_i;
  assign mst_penable_o = slv_penable_i;
  assign mst_pwrite_o  = slv_pwrite_i;
  assign mst_pwdata_o  = slv_pwdata_i;
  assign mst_pstrb_o   = slv_pstrb_i;

  apb_addr_decode #(
    .NoMst    (NoMst),
    .AddrWidth(AddrWidth),
    .IdxWidth (IdxW)
  ) u_decode (
    .addr       (slv_paddr_i),
    .base       (addr_base_i),
    .mask       (addr_mask_i),
    .match_valid(match_valid),
    .idx        (match_idx)
  );

  // Response mux for the registered port; one-hot forms for the setup and access selects.
  always_comb begin
    match_onehot = '0;
    sel_onehot   = '0;
    sel_pready   = 1'b0;
    sel_pslverr  = 1'b0;
    sel_prdata   = '0;
    for (int i = 0; i < int'(NoMst); i++) begin
      match_onehot[i] = (match_idx == IdxW'(i));
      if (sel_q == IdxW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_pready    = mst_pready_i[i];
        sel_pslverr   = mst_pslverr_i[i];
        sel_prdata    = mst_prdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    psel    = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (slv_psel_i && !slv_penable_i) begin
          if (match_valid) begin
            psel    = match_onehot;
            sel_d   = match_idx;
            cnt_d   = '0;
            state_d = StAccess;
          end else begin
            state_d = StDecErr;
          end
        end
      end
      StAccess: begin
        if (!slv_psel_i) begin
          // Requester abandoned the transfer: drop it quietly.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          psel    = sel_onehot;
          pready  = sel_pready;
          pslverr = sel_pslverr;
          prdata  = sel_prdata;
          if (sel_pready) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (TimeoutCycles != 0 && cnt_q == CntW'(TimeoutCycles - 1)) begin
            state_d = StAbort;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDecErr: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = StIdle;
      end
      StAbort: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        timeout = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Responses and selects are held quiet for the whole reset cycle, not just after it.
  assign mst_psel_o    = rst_i ? '0   : psel;
  assign slv_pready_o  = rst_i ? 1'b0 : pready;
  assign slv_pslverr_o = rst_i ? 1'b0 : pslverr;
  assign slv_prdata_o  = rst_i ? '0   : prdata;
  assign timeout_o     = rst_i ? 1'b0 : timeout;

endmodule

// File: tb/tb_apb_demux_timeout.sv
// Directed bench for apb_demux_timeout: decode, priority, wait states, decode error,
// watchdog abort, back-to-back transfers, mid-transfer reset and dropped psel.
module tb_apb_demux_timeout;

  localparam int unsigned NoMst = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned TO    = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NoMst*AW-1:0] addr_base_i, addr_mask_i;
  logic [AW-1:0]     slv_paddr_i;
  logic [2:0]        slv_pprot_i;
  logic              slv_psel_i, slv_penable_i, slv_pwrite_i;
  logic [DW-1:0]     slv_pwdata_i;
  logic [DW/8-1:0]   slv_pstrb_i;
  logic              slv_pready_o, slv_pslverr_o;
  logic [DW-1:0]     slv_prdata_o;
  logic [AW-1:0]     mst_paddr_o;
  logic [2:0]        mst_pprot_o;
  logic              mst_penable_o, mst_pwrite_o;
  logic [DW-1:0]     mst_pwdata_o;
  logic [DW/8-1:0]   mst_pstrb_o;
  logic [NoMst-1:0]  mst_psel_o, mst_pready_i, mst_pslverr_i;
  logic [NoMst*DW-1:0] mst_prdata_i;
  logic              timeout_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  apb_demux_timeout #(
    .NoMst        (NoMst),
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_base_i  (addr_base_i),
    .addr_mask_i  (addr_mask_i),
    .slv_paddr_i  (slv_paddr_i),
    .slv_pprot_i  (slv_pprot_i),
    .slv_psel_i   (slv_psel_i),
    .slv_penable_i(slv_penable_i),
    .slv_pwrite_i (slv_pwrite_i),
    .slv_pwdata_i (slv_pwdata_i),
    .slv_pstrb_i  (slv_pstrb_i),
    .slv_pready_o (slv_pready_o),
    .slv_prdata_o (slv_prdata_o),
    .slv_pslverr_o(slv_pslverr_o),
    .mst_paddr_o  (mst_paddr_o),
    .mst_pprot_o  (mst_pprot_o),
    .mst_penable_o(mst_penable_o),
    .mst_pwrite_o (mst_pwrite_o),
    .mst_pwdata_o (mst_pwdata_o),
    .mst_pstrb_o  (mst_pstrb_o),
    .mst_psel_o   (mst_psel_o),
    .mst_pready_i (mst_pready_i),
    .mst_pslverr_i(mst_pslverr_i),
    .mst_prdata_i (mst_prdata_i),
    .timeout_o    (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic setup(input logic [AW-1:0] addr, input logic wr);
    slv_psel_i    = 1'b1;
    slv_penable_i = 1'b0;
    slv_paddr_i   = addr;
    slv_pwrite_i  = wr;
  endtask

  task automatic idle();
    slv_psel_i    = 1'b0;
    slv_penable_i = 1'b0;
  endtask

  // Port 2 never answers: 16 access cycles with pready low, then the abort response.
  task automatic run_timeout(input string tag);
    next_cycle(); setup(32'h0000_2400, 1'b0); mst_pready_i = 4'b0000;
    mid(); chk({tag, "_setup_psel"}, mst_psel_o, 4'b0100);
    for (int c = 0; c < int'(TO); c++) begin
      next_cycle(); slv_penable_i = 1'b1;
      mid();
      chk({tag, "_wait_pready"}, slv_pready_o, 1'b0);
      chk({tag, "_wait_timeout"}, timeout_o, 1'b0);
      chk({tag, "_wait_psel"}, mst_psel_o, 4'b0100);
    end
    next_cycle();
    mid();
    chk({tag, "_abort_pready"}, slv_pready_o, 1'b1);
    chk({tag, "_abort_pslverr"}, slv_pslverr_o, 1'b1);
    chk({tag, "_abort_timeout"}, timeout_o, 1'b1);
    chk({tag, "_abort_psel"}, mst_psel_o, 4'b0000);
    chk({tag, "_abort_prdata"}, slv_prdata_o, 32'h0);
    next_cycle(); idle();
    mid();
    chk({tag, "_after_timeout"}, timeout_o, 1'b0);
    chk({tag, "_after_pready"}, slv_pready_o, 1'b0);
  endtask

  initial begin
    // Rule 0: exactly 0x2000; rule 1: 0x1xxx; rule 2: 0x2xxx; rule 3: 0x3xxx.
    addr_base_i   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
    addr_mask_i   = {32'h0000_F000, 32'h0000_F000, 32'h0000_F000, 32'h0000_FFFF};
    mst_prdata_i  = {32'hCAFE_F00D, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    mst_pslverr_i = 4'b0100;
    mst_pready_i  = 4'b0000;
    slv_pprot_i   = 3'b010;
    slv_pwdata_i  = 32'h5A5A_0001;
    slv_pstrb_i   = 4'hF;
    slv_paddr_i   = '0;
    slv_pwrite_i  = 1'b0;
    idle();
    rst_i = 1'b1;

    mid();
    chk("rst_psel", mst_psel_o, 4'b0000);
    chk("rst_pready", slv_pready_o, 1'b0);
    next_cycle(); setup(32'h0000_1004, 1'b1);
    mid();
    chk("rst_gate_psel", mst_psel_o, 4'b0000);
    chk("rst_gate_timeout", timeout_o, 1'b0);
    next_cycle(); rst_i = 1'b0; idle();
    mid();
    chk("idle_pready", slv_pready_o, 1'b0);

    // Write to port 1 with two wait states.
    next_cycle(); setup(32'h0000_1004, 1'b1);
    mid();
    chk("wr_setup_psel", mst_psel_o, 4'b0010);
    chk("wr_bcast_addr", mst_paddr_o, 32'h0000_1004);
    chk("wr_bcast_pprot", mst_pprot_o, 3'b010);
    chk("wr_setup_pready", slv_pready_o, 1'b0);
    for (int w = 0; w < 2; w++) begin
      next_cycle(); slv_penable_i = 1'b1;
      mid();
      chk("wr_wait_psel", mst_psel_o, 4'b0010);
      chk("wr_wait_pready", slv_pready_o, 1'b0);
    end
    next_cycle(); mst_pready_i = 4'b0010;
    mid();
    chk("wr_done_pready", slv_pready_o, 1'b1);
    chk("wr_done_pslverr", slv_pslverr_o, 1'b0);
    chk("wr_done_penable", mst_penable_o, 1'b1);
    next_cycle(); idle(); mst_pready_i = 4'b0000;
    mid();
    chk("wr_idle_psel", mst_psel_o, 4'b0000);

    // Read with no matching rule.
    next_cycle(); setup(32'hDEAD_0000, 1'b0);
    mid();
    chk("decerr_setup_psel", mst_psel_o, 4'b0000);
    chk("decerr_setup_pready", slv_pready_o, 1'b0);
    next_cycle(); slv_penable_i = 1'b1;
    mid();
    chk("decerr_pready", slv_pready_o, 1'b1);
    chk("decerr_pslverr", slv_pslverr_o, 1'b1);
    chk("decerr_prdata", slv_prdata_o, 32'h0);
    chk("decerr_psel", mst_psel_o, 4'b0000);
    next_cycle(); idle();

    // 0x2000 matches rules 0 and 2; port 0 must win.
    next_cycle(); setup(32'h0000_2000, 1'b0);
    mid();
    chk("prio_setup_psel", mst_psel_o, 4'b0001);
    next_cycle(); slv_penable_i = 1'b1; mst_pready_i = 4'b0101;
    mid();
    chk("prio_access_psel", mst_psel_o, 4'b0001);
    chk("prio_pready", slv_pready_o, 1'b1);
    chk("prio_pslverr", slv_pslverr_o, 1'b0);
    chk("prio_prdata", slv_prdata_o, 32'h1111_0000);
    next_cycle(); idle(); mst_pready_i = 4'b0000;

    // Back-to-back zero-wait reads: port 0 then port 3.
    next_cycle(); setup(32'h0000_2000, 1'b0); mst_pready_i = 4'b1001;
    mid();
    chk("b2b0_setup_psel", mst_psel_o, 4'b0001);
    next_cycle(); slv_penable_i = 1'b1;
    mid();
    chk("b2b0_pready", slv_pready_o, 1'b1);
    chk("b2b0_prdata", slv_prdata_o, 32'h1111_0000);
    next_cycle(); setup(32'h0000_3000, 1'b0);
    mid();
    chk("b2b3_setup_psel", mst_psel_o, 4'b1000);
    next_cycle(); slv_penable_i = 1'b1;
    mid();
    chk("b2b3_psel", mst_psel_o, 4'b1000);
    chk("b2b3_pready", slv_pready_o, 1'b1);
    chk("b2b3_prdata", slv_prdata_o, 32'hCAFE_F00D);
    next_cycle(); idle(); mst_pready_i = 4'b0000;

    run_timeout("to");

    // Reset on the 5th wait cycle, then a fresh transfer must take the full 16 cycles.
    next_cycle(); setup(32'h0000_2400, 1'b0);
    for (int w = 0; w < 4; w++) begin
      next_cycle(); slv_penable_i = 1'b1;
    end
    next_cycle(); rst_i = 1'b1;
    mid();
    chk("rstmid_psel", mst_psel_o, 4'b0000);
    chk("rstmid_pready", slv_pready_o, 1'b0);
    chk("rstmid_pslverr", slv_pslverr_o, 1'b0);
    chk("rstmid_prdata", slv_prdata_o, 32'h0);
    next_cycle(); rst_i = 1'b0;
    mid();
    chk("postrst_psel", mst_psel_o, 4'b0000);
    chk("postrst_pready", slv_pready_o, 1'b0);
    chk("postrst_pslverr", slv_pslverr_o, 1'b0);
    chk("postrst_timeout", timeout_o, 1'b0);
    next_cycle(); idle();
    run_timeout("rst_to");

    // Requester drops psel mid-access: back to idle, no abort, next setup accepted.
    next_cycle(); setup(32'h0000_2400, 1'b0);
    next_cycle(); slv_penable_i = 1'b1;
    next_cycle(); idle();
    mid();
    chk("drop_psel", mst_psel_o, 4'b0000);
    chk("drop_pready", slv_pready_o, 1'b0);
    chk("drop_timeout", timeout_o, 1'b0);
    next_cycle(); setup(32'h0000_1004, 1'b1);
    mid();
    chk("drop_next_psel", mst_psel_o, 4'b0010);
    next_cycle(); slv_penable_i = 1'b1; mst_pready_i = 4'b0010;
    mid();
    chk("drop_next_pready", slv_pready_o, 1'b1);
    next_cycle(); idle(); mst_pready_i = 4'b0000;
    mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
